stack_arb: RTL and testbench

Arbiter and sequencer that shares a single LIFO stack between `REQ_N` requesters. Each cycle it selects at most one push/pop request by round-robin and maintains the stack pointer and full/empty status. It drives the single-port stack storage and returns one response per accepted request. It sits between requester-side ports and a synchronous-read storage RAM.

---
 rtl/stack_arb_if.sv | 45 ++++
 rtl/stack_arb.sv | 140 ++++++++++++++
 tb/tb_stack_arb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stack_arb_if.sv
// rtl/stack_arb_if.sv - requester, response and storage signals of stack_arb
//
// Purpose: groups the requester handshake, the response channel and the
// single-port storage bus of the shared stack arbiter.
// Ports (signals):
//   i_req_vld/i_req_push/i_req_dat  per-requester request (REQ_N wide)
//   o_req_rdy                       one-hot grant
//   o_mem_wen/o_mem_ren/o_mem_addr/o_mem_wdat, i_mem_rdat  storage bus
//   o_rsp_vld/o_rsp_id/o_rsp_push/o_rsp_err/o_rsp_dat      response
// Modports: master = requesters + storage model, slave = arbiter.
interface stack_arb_if #(
    parameter int REQ_N  = 4,
    parameter int W      = 32,
    parameter int ADDR_W = 4,
    parameter int ID_W   = 2
);
    logic [REQ_N-1:0]        i_req_vld;
    logic [REQ_N-1:0]        i_req_push;
    logic [REQ_N-1:0][W-1:0] i_req_dat;
    logic [REQ_N-1:0]        o_req_rdy;

    logic                    o_mem_wen;
    logic                    o_mem_ren;
    logic [ADDR_W-1:0]       o_mem_addr;
    logic [W-1:0]            o_mem_wdat;
    logic [W-1:0]            i_mem_rdat;

    logic                    o_rsp_vld;
    logic [ID_W-1:0]         o_rsp_id;
    logic                    o_rsp_push;
    logic                    o_rsp_err;
    logic [W-1:0]            o_rsp_dat;

    modport master (
        output i_req_vld, i_req_push, i_req_dat, i_mem_rdat,
        input  o_req_rdy, o_mem_wen, o_mem_ren, o_mem_addr, o_mem_wdat,
        input  o_rsp_vld, o_rsp_id, o_rsp_push, o_rsp_err, o_rsp_dat
    );

    modport slave (
        input  i_req_vld, i_req_push, i_req_dat, i_mem_rdat,
        output o_req_rdy, o_mem_wen, o_mem_ren, o_mem_addr, o_mem_wdat,
        output o_rsp_vld, o_rsp_id, o_rsp_push, o_rsp_err, o_rsp_dat
    );
endinterface

// File: rtl/stack_arb.sv
// rtl/stack_arb.sv - round-robin arbiter sharing one LIFO stack between requesters
//
// Purpose: grants at most one push/pop per cycle (round-robin from rr),
// drives the synchronous-read stack storage, tracks occupancy and returns
// one response per accepted request in the following cycle.
// Ports:
//   clk      clock
//   arst     asynchronous active-high reset
//   i_flush  synchronous stack clear (blocks grants for that cycle)
//   o_count  occupancy, o_full = (count == N), o_empty = (count == 0)
//   bus      stack_arb_if.slave: requests, grant, storage bus, response
module stack_arb #(
    parameter int REQ_N  = 4,
    parameter int N      = 16,
    parameter int W      = 32,
    parameter int ADDR_W = $clog2(N),
    parameter int CNT_W  = $clog2(N + 1),
    parameter int ID_W   = $clog2(REQ_N)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    stack_arb_if.slave       bus
);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  rr;

    logic             rsp_vld;
    logic [ID_W-1:0]  rsp_id;
    logic             rsp_push;
    logic             rsp_err;
    logic             pop_pend;

    logic [REQ_N-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             found;
    logic             is_push;
    logic             is_full;
    logic             is_empty;
    logic             do_wen;
    logic             do_ren;
    logic [CNT_W-1:0] cnt_m1;

    assign is_full  = (count == N_CNT);
    assign is_empty = (count == '0);
    assign cnt_m1   = count - CNT_W'(1);

    // Rotating priority scan: first valid requester at or above rr, wrapping.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < REQ_N; k++) begin
            int idx;
            idx = int'(rr) + k;
            if (idx >= REQ_N) begin
                idx = idx - REQ_N;
            end
            if (!found && bus.i_req_vld[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        // Flush owns the cycle: nothing is accepted while the stack is cleared.
        if (i_flush) begin
            found  = 1'b0;
            gnt_id = '0;
        end
        if (found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    assign is_push = bus.i_req_push[gnt_id];
    // Push-on-full and pop-on-empty are still accepted but never touch storage.
    assign do_wen  = found && is_push && !is_full;
    assign do_ren  = found && !is_push && !is_empty;

    always_comb begin
        bus.o_mem_addr = '0;
        bus.o_mem_wdat = '0;
        if (do_wen) begin
            bus.o_mem_addr = count[ADDR_W-1:0];
            bus.o_mem_wdat = bus.i_req_dat[gnt_id];
        end else if (do_ren) begin
            bus.o_mem_addr = cnt_m1[ADDR_W-1:0];
        end
    end

    assign bus.o_req_rdy = gnt;
    assign bus.o_mem_wen = do_wen;
    assign bus.o_mem_ren = do_ren;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count    <= '0;
            rr       <= '0;
            rsp_vld  <= 1'b0;
            rsp_id   <= '0;
            rsp_push <= 1'b0;
            rsp_err  <= 1'b0;
            pop_pend <= 1'b0;
        end else begin
            if (i_flush) begin
                count <= '0;
            end else if (do_wen) begin
                count <= count + CNT_W'(1);
            end else if (do_ren) begin
                count <= cnt_m1;
            end

            if (found) begin
                rr <= (gnt_id == ID_W'(REQ_N - 1)) ? '0 : gnt_id + ID_W'(1);
            end

            rsp_vld  <= found;
            rsp_id   <= gnt_id;
            rsp_push <= found && is_push;
            rsp_err  <= found && !do_wen && !do_ren;
            pop_pend <= do_ren;
        end
    end

    // Read data arrives from storage in the response cycle and is forwarded
    // unregistered, so only the pop-pending flag is held here.
    assign bus.o_rsp_vld  = rsp_vld;
    assign bus.o_rsp_id   = rsp_id;
    assign bus.o_rsp_push = rsp_push;
    assign bus.o_rsp_err  = rsp_err;
    assign bus.o_rsp_dat  = pop_pend ? bus.i_mem_rdat : '0;

    assign o_count = count;
    assign o_full  = is_full;
    assign o_empty = is_empty;
endmodule

// File: tb/tb_stack_arb.sv
// tb/tb_stack_arb.sv - self-checking bench for stack_arb against a queue-based stack model
module tb_stack_arb;
    localparam int REQ_N  = 4;
    localparam int N      = 16;
    localparam int W      = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;
    localparam int ID_W   = 2;

    logic             clk = 1'b0;
    logic             arst;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    stack_arb_if #(.REQ_N(REQ_N), .W(W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

    stack_arb #(.REQ_N(REQ_N), .N(N), .W(W)) dut (
        .clk     (clk),
        .arst    (arst),
        .i_flush (flush),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous-read storage attached to the memory bus.
    logic [W-1:0] mem [N];
    always @(posedge clk) begin
        if (bus.o_mem_wen) mem[bus.o_mem_addr] <= bus.o_mem_wdat;
        if (bus.o_mem_ren) bus.i_mem_rdat <= mem[bus.o_mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference: stack contents as a queue, rr as an integer, one pending response.
    logic [W-1:0] stk [$];
    int           m_rr = 0;
    logic         exp_vld = 1'b0;
    int           exp_id = 0;
    logic         exp_push = 1'b0;
    logic         exp_err = 1'b0;
    logic [W-1:0] exp_dat = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check last response and this cycle's command, advance model.
    task automatic step(input logic [3:0] vld, input logic [3:0] push,
                        input logic [3:0][W-1:0] dat, input logic fl);
        int g;
        int sz;
        logic wen, ren;
        logic [ADDR_W-1:0] addr;
        logic [W-1:0] wdat;
        bus.i_req_vld  = vld;
        bus.i_req_push = push;
        bus.i_req_dat  = dat;
        flush          = fl;
        #1;
        chk("rsp_vld", 64'(bus.o_rsp_vld), 64'(exp_vld));
        if (exp_vld) begin
            chk("rsp_id",   64'(bus.o_rsp_id),   64'(exp_id));
            chk("rsp_push", 64'(bus.o_rsp_push), 64'(exp_push));
            chk("rsp_err",  64'(bus.o_rsp_err),  64'(exp_err));
            chk("rsp_dat",  64'(bus.o_rsp_dat),  64'(exp_dat));
        end
        g = -1;
        if (!fl) begin
            for (int k = 0; k < REQ_N; k++) begin
                if (g < 0 && vld[(m_rr + k) % REQ_N]) g = (m_rr + k) % REQ_N;
            end
        end
        sz   = stk.size();
        wen  = (g >= 0) && push[g] && (sz < N);
        ren  = (g >= 0) && !push[g] && (sz > 0);
        addr = wen ? ADDR_W'(sz) : (ren ? ADDR_W'(sz - 1) : '0);
        wdat = wen ? dat[g] : '0;
        chk("req_rdy",  64'(bus.o_req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("mem_wen",  64'(bus.o_mem_wen), 64'(wen));
        chk("mem_ren",  64'(bus.o_mem_ren), 64'(ren));
        chk("mem_addr", 64'(bus.o_mem_addr), 64'(addr));
        chk("mem_wdat", 64'(bus.o_mem_wdat), 64'(wdat));
        chk("count",    64'(count), 64'(sz));
        chk("full",     64'(full),  64'(sz == N));
        chk("empty",    64'(empty), 64'(sz == 0));
        @(posedge clk);
        exp_vld  = (g >= 0);
        exp_id   = (g >= 0) ? g : 0;
        exp_push = wen || ((g >= 0) && push[g]);
        exp_err  = (g >= 0) && !wen && !ren;
        exp_dat  = ren ? stk.pop_back() : '0;
        if (wen) stk.push_back(dat[g]);
        if (fl) stk.delete();
        if (g >= 0) m_rr = (g + 1) % REQ_N;
        #1;
    endtask

    initial begin
        logic [3:0][W-1:0] d;
        int guard;
        arst = 1'b1;
        flush = 1'b0;
        bus.i_req_vld  = '0;
        bus.i_req_push = '0;
        bus.i_req_dat  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_vld",  64'(bus.o_rsp_vld),  64'd0);
        chk("rst_rsp_id",   64'(bus.o_rsp_id),   64'd0);
        chk("rst_rsp_push", 64'(bus.o_rsp_push), 64'd0);
        chk("rst_rsp_err",  64'(bus.o_rsp_err),  64'd0);
        chk("rst_rsp_dat",  64'(bus.o_rsp_dat),  64'd0);
        chk("rst_count",    64'(count), 64'd0);
        chk("rst_empty",    64'(empty), 64'd1);
        chk("rst_full",     64'(full),  64'd0);
        chk("rst_rdy",      64'(bus.o_req_rdy),  64'd0);
        chk("rst_wen",      64'(bus.o_mem_wen),  64'd0);
        chk("rst_ren",      64'(bus.o_mem_ren),  64'd0);
        chk("rst_addr",     64'(bus.o_mem_addr), 64'd0);
        chk("rst_wdat",     64'(bus.o_mem_wdat), 64'd0);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Requester 1: push 0xA, 0xB, pop, pop.
        d = '0; d[1] = 32'hA;
        step(4'b0010, 4'b0010, d, 1'b0);
        d[1] = 32'hB;
        step(4'b0010, 4'b0010, d, 1'b0);
        step(4'b0010, 4'b0000, d, 1'b0);
        step(4'b0010, 4'b0000, d, 1'b0);
        step(4'b0000, 4'b0000, d, 1'b0);

        // Fill to N from random requesters, then push on full from requester 2.
        guard = 0;
        while (stk.size() < N && guard < 200) begin
            for (int i = 0; i < REQ_N; i++) d[i] = $urandom;
            step(4'($urandom_range(1, 15)), 4'hF, d, 1'b0);
            guard++;
        end
        chk("fill_done", 64'(stk.size()), 64'(N));
        d[2] = 32'h55;
        step(4'b0100, 4'hF, d, 1'b0);

        // All requesters hold pop: drains in LIFO order, last one hits empty.
        for (int i = 0; i <= N; i++) step(4'hF, 4'h0, d, 1'b0);
        step(4'b1000, 4'h0, d, 1'b0);
        step(4'b0000, 4'h0, d, 1'b0);

        // Randomized mix with occasional flush.
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < REQ_N; j++) d[j] = $urandom;
            step(4'($urandom_range(0, 15)), 4'($urandom), d,
                 ($urandom_range(0, 19) == 0));
        end

        // Flush with requester 0 valid after three pushes.
        step(4'b0000, 4'h0, d, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d[0] = 32'h100 + i;
            step(4'b0001, 4'b0001, d, 1'b0);
        end
        step(4'b0001, 4'b0001, d, 1'b1);
        step(4'b0000, 4'h0, d, 1'b0);

        // Reset one cycle after a grant: the pending response is dropped.
        d[0] = 32'hDEAD;
        step(4'b0001, 4'b0001, d, 1'b0);
        bus.i_req_vld = '0;
        arst = 1'b1;
        #1;
        chk("arst_rsp_vld", 64'(bus.o_rsp_vld), 64'd0);
        chk("arst_count",   64'(count), 64'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        stk.delete();
        m_rr = 0;
        exp_vld = 1'b0;
        step(4'b0000, 4'h0, d, 1'b0);
        step(4'b0000, 4'h0, d, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
